// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: registered sx/sy, sync, blank, DE and line/frame strobes.
// Optional genlock to an external vsync reference when VTG_GENLOCK_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int CNT_W    = 12
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             ce,
`ifdef VTG_GENLOCK_EN
  input  logic             vsync_ref,
  output logic             locked,
`endif
  output logic [CNT_W-1:0] sx,
  output logic [CNT_W-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             hblank,
  output logic             vblank,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int MAX_TOT  = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      (64'd1 << CNT_W) < 64'(MAX_TOT)) begin : g_param_err
    $error("video_timing_gen: bad timing parameters or CNT_W too small");
  end

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_S   = cnt_t'(HS_START);
  localparam cnt_t HS_E   = cnt_t'(HS_START + H_SYNC);
  localparam cnt_t VS_S   = cnt_t'(VS_START);
  localparam cnt_t VS_E   = cnt_t'(VS_START + V_SYNC);
  localparam logic HP     = H_POL[0];
  localparam logic VP     = V_POL[0];

  cnt_t hpos, vpos, nat_h, nat_v, nxt_h, nxt_v;
  logic in_hs, in_vs;

`ifdef VTG_GENLOCK_EN
  logic ref_q, pending, one_ok, corr;
`endif

  // Flags are decoded from the position about to be presented, so sx/sy and flags stay aligned.
  always_comb begin
    nat_h = (hpos == H_LAST) ? '0 : hpos + 1'b1;
    nat_v = vpos;
    if (hpos == H_LAST) nat_v = (vpos == V_LAST) ? '0 : vpos + 1'b1;
    nxt_h = nat_h;
    nxt_v = nat_v;
`ifdef VTG_GENLOCK_EN
    corr = (nat_h != '0) || (nat_v != VS_S);
    if (pending) begin
      nxt_h = '0;
      nxt_v = VS_S;
    end
`endif
    in_hs = (nxt_h >= HS_S) && (nxt_h < HS_E);
    in_vs = (nxt_v >= VS_S) && (nxt_v < VS_E);
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      sx          <= '0;
      sy          <= '0;
      hsync       <= ~HP;
      vsync       <= ~VP;
      de          <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        hpos        <= nxt_h;
        vpos        <= nxt_v;
        sx          <= nxt_h;
        sy          <= nxt_v;
        hsync       <= in_hs ~^ HP;
        vsync       <= in_vs ~^ VP;
        de          <= (nxt_h < H_ACT) && (nxt_v < V_ACT);
        hblank      <= nxt_h >= H_ACT;
        vblank      <= nxt_v >= V_ACT;
        line_start  <= nxt_h == '0;
        frame_start <= (nxt_h == '0) && (nxt_v == '0);
      end
    end
  end

`ifdef VTG_GENLOCK_EN
  // Lock needs two consecutive reference edges that land where the raster already was.
  always_ff @(posedge clk_pix) begin
    ref_q <= vsync_ref;
    if (rst) begin
      pending <= 1'b0;
      one_ok  <= 1'b0;
      locked  <= 1'b0;
    end else begin
      if (ce && pending) begin
        if (corr) begin
          one_ok <= 1'b0;
          locked <= 1'b0;
        end else begin
          one_ok <= 1'b1;
          if (one_ok) locked <= 1'b1;
        end
      end
      if (vsync_ref && !ref_q) pending <= 1'b1;
      else if (ce)             pending <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for MiSTer cores. It replaces fixed-mode 720p timing modules.
- Any mode is set by active/porch/sync parameters, with selectable sync polarity.
- Adds a pixel clock-enable, registered outputs, separate blank flags, and line/frame strobes.
- Drives VGA_HS/VGA_VS/VGA_DE and pixel-address generation in the emu top level.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch in pixels
- H_SYNC, 40, hsync width in pixels
- H_BP, 220, horizontal back porch in pixels
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch in lines
- V_SYNC, 5, vsync width in lines
- V_BP, 20, vertical back porch in lines
- H_POL, 1, hsync active level (1 = positive)
- V_POL, 1, vsync active level (1 = positive)
- CNT_W, 12, width of sx/sy

Ports:
- clk_pix input 1: pixel clock.
- rst input 1: synchronous, active-high reset.
- ce input 1: pixel advance enable. Tie to 1 for one pixel per clock.
- sx output CNT_W: horizontal position, 0..H_TOTAL-1.
- sy output CNT_W: vertical position, 0..V_TOTAL-1.
- hsync output 1: horizontal sync, level set by H_POL.
- vsync output 1: vertical sync, level set by V_POL.
- de output 1: data enable, high when sx<H_ACTIVE and sy<V_ACTIVE.
- hblank output 1: high when sx>=H_ACTIVE.
- vblank output 1: high when sy>=V_ACTIVE.
- line_start output 1: one-clk strobe on entering sx=0.
- frame_start output 1: one-clk strobe on entering sx=0, sy=0.

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - HS_START = H_ACTIVE+H_FP
  - VS_START = V_ACTIVE+V_FP
- Elaboration check: every timing parameter must be >=1 and 2^CNT_W >= max(H_TOTAL,V_TOTAL). Otherwise $error.
- Register update rule:
  - All outputs are registered, and every flag is decoded from the same position presented on sx/sy in that cycle.
  - No combinational path from counters to outputs.
- Reset (rst=1 at an edge), including mid-frame:
  - sx=0, sy=0, de=0, hblank=1, vblank=1.
  - hsync=~H_POL, vsync=~V_POL.
  - line_start=0, frame_start=0.
  - Internal position is set to (H_TOTAL-1, V_TOTAL-1).
- First ce=1 edge after rst deasserts:
  - Outputs present (0,0): de=1, hblank=0, vblank=0.
  - line_start=1 and frame_start=1 for that one cycle.
- Advance, on each edge with ce=1:
  - If sx==H_TOTAL-1: sx wraps to 0, and sy increments (sy==V_TOTAL-1 wraps to 0).
  - Otherwise sx increments.
- Hold, on each edge with ce=0: sx, sy, sync, de and blank outputs hold their values.
- Strobes: line_start and frame_start are high for exactly one clk_pix cycle after the advancing edge, then 0 even if ce stays low.
- Sync windows:
  - hsync is at level H_POL when HS_START <= sx < HS_START+H_SYNC.
  - vsync is at level V_POL when VS_START <= sy < VS_START+V_SYNC. vsync changes only together with the sx=0 transition.
- Latency: 0 cycles between sx/sy and their flags; 1 clk from a ce edge to the outputs.
- Simultaneous rst and ce: rst wins.

Optional Feature:
- Macro: VTG_GENLOCK_EN.
- With the macro defined, two ports are added:
  - input vsync_ref: active-high, synchronous to clk_pix.
  - output locked.
- Rising-edge detection on vsync_ref uses one register.
- A detected edge sets a pending flag. At the next ce=1 edge the position is forced to (0, VS_START), the normal flag decoding applies, and pending clears.
- If the natural next position already equals (0, VS_START), that jump counts as "no correction".
- locked behaviour:
  - Set after two consecutive ref edges with no correction.
  - Cleared on any correction and on rst.
  - Reset value 0.
- rst clears pending.
- Without the macro, vsync_ref and locked do not exist. The generator free-runs exactly as described in Behaviour.

Test Plan:
- Small mode, H_ACTIVE=8 H_FP=2 H_SYNC=2 H_BP=2, V_ACTIVE=4 V_FP=1 V_SYNC=1 V_BP=1, ce=1 -> 14 clks per line and 98 clks per frame; hsync high at sx=10..11; vsync high at sy=5; de high for 32 clks per frame; frame_start every 98 clks.
- Same mode with ce toggling 1,0,0 -> each position is held for 3 clks; line_start is high for 1 clk only; frame period is 294 clks.
- Defaults 1280x720 -> sx wraps at 1649, sy wraps at 749; hsync pulse at sx=1390..1429; de count is 921600 per frame.
- H_POL=0, V_POL=0 -> during reset and in active video, hsync=vsync=1; they are low only in the sync windows.
- rst asserted at sx=5, sy=2 for 1 clk -> next cycle shows reset values; first ce edge shows (0,0) with frame_start=1.
- VTG_GENLOCK_EN on the small mode:
  - vsync_ref pulse at sy=1 -> next ce gives (0,5), locked=0.
  - Further pulses every 98 clks aligned to that phase -> locked=1 after the second aligned edge.
  - A misaligned pulse -> locked=0.
